inst_issue_seq: RTL and testbench

- Instruction sequencer that generates the 29-bit instruction stream consumed by the ALU datapath: the producing end of the INST → D_out/Over_Flow interface.
- Holds a small loadable program RAM and issues one instruction every HOLD cycles.
- Supports one hardware loop and samples the ALU result/overflow at the end of each hold window.
- Replaces hand-written stimulus sequences for programs such as the iterative add/addi sum.

---
 rtl/inst_issue_seq.sv | 180 ++++++++++++++++++
 tb/tb_inst_issue_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_seq.sv
// ============================================================================
// Module   : inst_issue_seq
// Purpose  : Instruction sequencer feeding an ALU datapath. A small program
//            RAM is loaded while idle. After start, the program is issued one
//            instruction every HOLD cycles, with one optional hardware loop.
//            The ALU result and overflow flag are sampled on the last cycle
//            of each hold window.
// Ports    : clk, rst_n         - clock (rising edge), sync active-low reset
//            wr_en/addr/data    - program RAM write port (honoured in IDLE)
//            start, prog_len    - start pulse, program length 1..DEPTH
//            loop_start/end/cnt - loop body bounds and extra iterations
//            halt_on_ovf        - abort the program on ALU overflow
//            alu_d, alu_ovf     - ALU result / overflow inputs
//            inst, inst_valid   - issued instruction and its qualifier
//            last_result        - last sampled alu_d
//            busy, done         - running flag, one-cycle completion pulse
//            ovf_err            - sticky abort-on-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_issue_seq #(
  parameter int DEPTH = 32,
  parameter int HOLD  = 4,
  parameter int IW    = 29,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [IW-1:0]              wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic [$clog2(DEPTH)-1:0]   loop_start,
  input  logic [$clog2(DEPTH)-1:0]   loop_end,
  input  logic [7:0]                 loop_cnt,
  input  logic                       halt_on_ovf,
  input  logic [DW-1:0]              alu_d,
  input  logic                       alu_ovf,
  output logic [IW-1:0]              inst,
  output logic                       inst_valid,
  output logic [DW-1:0]              last_result,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_pc;
  logic [HCW-1:0]  r_hold;
  logic [7:0]      r_iter;
  logic [AW:0]     r_len;
  logic [AW-1:0]   r_lstart;
  logic [AW-1:0]   r_lend;
  logic            r_halt;
  logic            r_loop_en;
  logic [DW-1:0]   r_last;
  logic            r_ovf_err;

  logic            w_start_ok;
  logic            w_loop_ok;
  logic            w_last_hold;
  logic            w_abort;
  logic            w_loop_back;
  logic            w_at_end;

  // A start is only accepted with a non-empty program that fits the RAM.
  assign w_start_ok  = start && (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));
  // The loop is only honoured when its body lies wholly inside the program.
  assign w_loop_ok   = (loop_start <= loop_end) && ({1'b0, loop_end} < prog_len);
  assign w_last_hold = (r_hold == HCW'(HOLD - 1));
  assign w_abort     = alu_ovf && r_halt;
  assign w_loop_back = r_loop_en && (r_pc == r_lend) && (r_iter != 8'd0);
  assign w_at_end    = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

  // Next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    inst        = '0;
    inst_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        inst       = r_mem[r_pc];
        inst_valid = 1'b1;
        busy       = 1'b1;
        // Overflow abort outranks the loop branch, which outranks the end test.
        if (w_last_hold && (w_abort || (!w_loop_back && w_at_end)))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Program RAM: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) r_mem[wr_addr] <= wr_data;
  end

  // Sequencing datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_hold    <= '0;
      r_iter    <= '0;
      r_len     <= '0;
      r_lstart  <= '0;
      r_lend    <= '0;
      r_halt    <= 1'b0;
      r_loop_en <= 1'b0;
      r_last    <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_pc      <= '0;
            r_hold    <= '0;
            r_iter    <= loop_cnt;
            r_len     <= prog_len;
            r_lstart  <= loop_start;
            r_lend    <= loop_end;
            r_halt    <= halt_on_ovf;
            r_loop_en <= w_loop_ok;
            r_ovf_err <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_last_hold) begin
            r_hold <= '0;
            r_last <= alu_d;
            if (w_abort) begin
              r_ovf_err <= 1'b1;
            end else if (w_loop_back) begin
              r_pc   <= r_lstart;
              r_iter <= r_iter - 8'd1;
            end else if (!w_at_end) begin
              r_pc <= r_pc + AW'(1);
            end
          end else begin
            r_hold <= r_hold + HCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign last_result = r_last;
  assign ovf_err     = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_issue_seq.sv
`default_nettype none

module tb_inst_issue_seq;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [28:0] wr_data = '0;
  logic        start = 1'b0;
  logic [5:0]  prog_len = '0;
  logic [4:0]  loop_start = '0;
  logic [4:0]  loop_end = '0;
  logic [7:0]  loop_cnt = '0;
  logic        halt_on_ovf = 1'b0;
  logic [15:0] alu_d = '0;
  logic        alu_ovf = 1'b0;
  logic [28:0] inst;
  logic        inst_valid;
  logic [15:0] last_result;
  logic        busy;
  logic        done;
  logic        ovf_err;

  inst_issue_seq #(.DEPTH(32), .HOLD(HOLD), .IW(29), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len),
    .loop_start(loop_start), .loop_end(loop_end), .loop_cnt(loop_cnt),
    .halt_on_ovf(halt_on_ovf), .alu_d(alu_d), .alu_ovf(alu_ovf),
    .inst(inst), .inst_valid(inst_valid), .last_result(last_result),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: add rd=rs+rt, addi rd=rs+imm, R0 reads as zero.
  function automatic logic [15:0] alu_fn(input logic [28:0] w, input logic [15:0] ra,
                                         input logic [15:0] rb);
    if (w[28:24] == 5'b00100)      return ra + rb;
    else if (w[28:24] == 5'b00101) return ra + w[15:0];
    else                           return 16'h0;
  endfunction

  function automatic bit wr_ok(input logic [28:0] w);
    return ((w[28:24] == 5'b00100) || (w[28:24] == 5'b00101)) && (w[23:20] != 4'd0);
  endfunction

  logic [28:0] mem_m [32];
  logic [15:0] env_regs [16];
  logic [28:0] obs [$];
  logic [28:0] win_inst, pend_inst;
  bit          pend;
  int          phase, ovf_at, busy_cnt, done_cnt;

  // Environment: observes issued windows and plays the ALU. Register
  // write-back lands one cycle after the window closes so the value the
  // sequencer samples belongs to the instruction that was on the bus.
  always @(negedge clk) begin
    if (pend) begin
      if (wr_ok(pend_inst))
        env_regs[pend_inst[23:20]] = alu_fn(pend_inst, env_regs[pend_inst[19:16]],
                                            env_regs[pend_inst[15:12]]);
      pend = 1'b0;
    end
    alu_ovf = 1'b0;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (inst_valid) begin
      if (phase == 0) begin
        win_inst = inst;
        obs.push_back(inst);
      end else begin
        chk("hold_stable", inst, win_inst);
      end
      phase++;
      if (phase == HOLD) begin
        phase     = 0;
        pend      = 1'b1;
        pend_inst = win_inst;
        if (ovf_at == obs.size() - 1) alu_ovf = 1'b1;
      end
    end
    alu_d = alu_fn(inst, env_regs[inst[19:16]], env_regs[inst[15:12]]);
  end

  task automatic env_clear(input int ovf);
    @(posedge clk); #1;
    foreach (env_regs[i]) env_regs[i] = '0;
    obs.delete();
    phase = 0; pend = 1'b0; busy_cnt = 0; done_cnt = 0; ovf_at = ovf;
  endtask

  task automatic load(input int a, input logic [28:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic drive_params(input int len, input int ls, input int le, input int cnt,
                              input bit halt);
    prog_len = len[5:0]; loop_start = ls[4:0]; loop_end = le[4:0];
    loop_cnt = cnt[7:0]; halt_on_ovf = halt;
  endtask

  task automatic run_prog(input string nm, input int len, input int ls, input int le,
                          input int cnt, input bit halt, input int ovf, input bit interfere);
    int          exp_pc [$];
    logic [15:0] rm [16];
    logic [15:0] exp_last, r;
    logic [28:0] w;
    bit          exp_err, got_done;
    int          n;
    // Reference: expand the program into its pc trace
    if (ls <= le && le < len) begin
      for (int p = 0; p < ls; p++) exp_pc.push_back(p);
      for (int k = 0; k <= cnt; k++)
        for (int p = ls; p <= le; p++) exp_pc.push_back(p);
      for (int p = le + 1; p < len; p++) exp_pc.push_back(p);
    end else begin
      for (int p = 0; p < len; p++) exp_pc.push_back(p);
    end
    exp_err = 1'b0;
    if (halt && ovf >= 0 && ovf < exp_pc.size()) begin
      while (exp_pc.size() > ovf + 1) void'(exp_pc.pop_back());
      exp_err = 1'b1;
    end
    foreach (rm[i]) rm[i] = '0;
    exp_last = '0;
    foreach (exp_pc[i]) begin
      w = mem_m[exp_pc[i]];
      r = alu_fn(w, rm[w[19:16]], rm[w[15:12]]);
      exp_last = r;
      if (wr_ok(w)) rm[w[23:20]] = r;
    end

    env_clear(ovf);
    @(negedge clk);
    drive_params(len, ls, le, cnt, halt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ":first_inst"}, inst, mem_m[0]);
    chk({nm, ":first_valid"}, inst_valid, 1);
    chk({nm, ":err_clr"}, ovf_err, 0);
    got_done = 1'b0;
    for (int k = 0; k < 40000 && !got_done; k++) begin
      @(negedge clk);
      if (interfere && k == 5) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = ~mem_m[0];
        start = 1'b1; prog_len = 6'd1;
      end else if (interfere && k == 6) begin
        wr_en = 1'b0; start = 1'b0; prog_len = len[5:0];
      end
      if (done) got_done = 1'b1;
    end
    chk({nm, ":done_seen"}, got_done, 1);
    chk({nm, ":done_inst0"}, inst, 0);
    chk({nm, ":done_valid0"}, inst_valid, 0);
    chk({nm, ":done_busy0"}, busy, 0);
    // A start presented in the DONE cycle must not launch a run.
    wr_en = 1'b0;
    drive_params(len, ls, le, cnt, halt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ":start_in_done"}, busy, 0);
    chk({nm, ":done_pulses"}, done_cnt, 1);
    chk({nm, ":busy_cycles"}, busy_cnt, HOLD * exp_pc.size());
    chk({nm, ":n_issued"}, obs.size(), exp_pc.size());
    n = (obs.size() < exp_pc.size()) ? obs.size() : exp_pc.size();
    for (int i = 0; i < n; i++) chk({nm, ":inst_seq"}, obs[i], mem_m[exp_pc[i]]);
    chk({nm, ":last_result"}, last_result, exp_last);
    chk({nm, ":ovf_err"}, ovf_err, exp_err);
  endtask

  initial begin
    int len, ls, le, op;
    logic [28:0] rw;
    foreach (env_regs[i]) env_regs[i] = '0;
    phase = 0; pend = 1'b0; busy_cnt = 0; done_cnt = 0; ovf_at = -1;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf_err", ovf_err, 0);
    chk("rst_last", last_result, 0);
    rst_n = 1'b1;

    load(0, 29'h5100000);
    load(1, 29'h5200000);
    load(2, 29'h4112000);
    load(3, 29'h5220001);

    run_prog("loop10", 4, 2, 3, 10, 1'b0, -1, 1'b0);
    chk("loop10:sum", last_result, 16'h000B);
    run_prog("loop0", 4, 2, 3, 0, 1'b0, -1, 1'b0);
    run_prog("ovf_halt", 4, 2, 3, 0, 1'b1, 2, 1'b0);
    chk("ovf_halt:12cyc", busy_cnt, 12);
    run_prog("ovf_nohalt", 4, 2, 3, 0, 1'b0, 2, 1'b0);
    run_prog("busy_wr", 4, 2, 3, 3, 1'b0, -1, 1'b1);
    run_prog("readback", 4, 2, 3, 3, 1'b0, -1, 1'b0);
    run_prog("bad_loop", 4, 3, 2, 5, 1'b0, -1, 1'b0);

    // Leave ovf_err set, then reset in the middle of a run.
    run_prog("pre_rst", 4, 2, 3, 0, 1'b1, 0, 1'b0);
    env_clear(-1);
    @(negedge clk);
    drive_params(4, 2, 3, 10, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_inst", inst, 0);
    chk("midrst_valid", inst_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last", last_result, 0);
    chk("midrst_ovf_err", ovf_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    run_prog("after_rst", 4, 2, 3, 10, 1'b0, -1, 1'b0);

    // Empty program: start must be ignored.
    env_clear(-1);
    @(negedge clk);
    drive_params(0, 0, 0, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("len0_busy", busy_cnt, 0);
    chk("len0_valid", inst_valid, 0);

    // Randomized programs and loop settings
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < 32; a++) begin
        op = $urandom_range(0, 3);
        rw = 29'($urandom);
        if (op == 0 || op == 1) rw[28:24] = 5'b00101;
        else if (op == 2)       rw[28:24] = 5'b00100;
        load(a, rw);
      end
      len = $urandom_range(1, 32);
      if ($urandom_range(0, 9) < 7) begin
        ls = $urandom_range(0, len - 1);
        le = $urandom_range(ls, len - 1);
      end else begin
        ls = $urandom_range(0, 31);
        le = $urandom_range(0, 31);
      end
      run_prog($sformatf("rnd%0d", t), len, ls, le, $urandom_range(0, 6),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
